// File: rtl/fighter_motion_pkg.sv
// Shared types and default geometry for the per-fighter motion controller.
// Both the horizontal controller and the jump arc import this package.
package fighter_motion_pkg;

   typedef enum logic [1:0] {
      H_WALK  = 2'd0,
      H_DASH  = 2'd1,
      H_KNOCK = 2'd2
   } h_state_t;

   typedef enum logic {
      V_GROUND = 1'b0,
      V_AIR    = 1'b1
   } v_state_t;

   // Playfield geometry; the fighter bounds sit EDGE_X in from either side.
   localparam int MAP_X  = 448;
   localparam int MAP_Y  = 352;
   localparam int EDGE_X = 160;

   localparam int DEF_X_W      = 11;
   localparam int DEF_Y_W      = 10;
   localparam int DEF_X_MIN    = EDGE_X;
   localparam int DEF_X_MAX    = MAP_X - EDGE_X;
   localparam int DEF_X_INIT   = MAP_X - EDGE_X;
   localparam int DEF_GROUND_Y = -(MAP_Y / 2);
   localparam int DEF_V        = 8;
   localparam int DEF_MAX_J    = 32;

   function automatic int cnt_bits(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/fighter_motion_jump_arc.sv
// Vertical motion: ground/air FSM, air tick counter, parabolic y and landed pulse.
// Every register advances only on tick; landed is high for the one clk after the landing tick.
module jump_arc
   import fighter_motion_pkg::*;
#(
   parameter int Y_W      = DEF_Y_W,
   parameter int GROUND_Y = DEF_GROUND_Y,
   parameter int V        = DEF_V,
   parameter int MAX_J    = DEF_MAX_J
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  start,
   output logic signed [Y_W-1:0] y,
   output logic                  air,
   output logic                  landed
);

   localparam int CNT_W = cnt_bits(MAX_J);
   localparam logic signed [15:0]    G16 = 16'(GROUND_Y);
   localparam logic signed [15:0]    V16 = 16'(V);
   localparam logic signed [Y_W-1:0] GY  = Y_W'(GROUND_Y);

   v_state_t              v_state, v_nxt;
   logic [CNT_W-1:0]      cnt, cnt_nxt, c;
   logic signed [Y_W-1:0] y_nxt;
   logic                  land_nxt;
   logic signed [15:0]    c16, arc16;

   function automatic logic signed [15:0] floor_ground(input logic signed [15:0] v);
      return (v < G16) ? G16 : v;
   endfunction

   // Height for air tick c, computed wide so the square cannot wrap before the floor clamp.
   always_comb begin
      c     = cnt + CNT_W'(1);
      c16   = 16'(c);
      arc16 = floor_ground(G16 + V16 * c16 - ((c16 * c16) >>> 2));
   end

   always_comb begin
      v_nxt    = v_state;
      cnt_nxt  = cnt;
      y_nxt    = y;
      land_nxt = 1'b0;
      if (tick) begin
         case (v_state)
            V_GROUND: begin
               if (start) begin
                  v_nxt   = V_AIR;
                  cnt_nxt = '0;
                  y_nxt   = GY;
               end
            end
            V_AIR: begin
               if (c == CNT_W'(MAX_J)) begin
                  v_nxt    = V_GROUND;
                  cnt_nxt  = '0;
                  y_nxt    = GY;
                  land_nxt = 1'b1;
               end else begin
                  cnt_nxt = c;
                  y_nxt   = Y_W'(arc16);
               end
            end
            default: v_nxt = V_GROUND;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_state <= V_GROUND;
         cnt     <= '0;
         y       <= GY;
         landed  <= 1'b0;
      end else begin
         v_state <= v_nxt;
         cnt     <= cnt_nxt;
         y       <= y_nxt;
         landed  <= land_nxt;
      end
   end

   assign air = (v_state == V_AIR);

endmodule

// File: rtl/fighter_motion.sv
// Per-fighter motion controller: walk, double-tap dash, knockback, facing and pose flags.
// Horizontal FSM and flags live here; the vertical arc is delegated to jump_arc.
module fighter_motion
   import fighter_motion_pkg::*;
#(
   parameter int X_W      = DEF_X_W,
   parameter int Y_W      = DEF_Y_W,
   parameter int X_MIN    = DEF_X_MIN,
   parameter int X_MAX    = DEF_X_MAX,
   parameter int X_INIT   = DEF_X_INIT,
   parameter int GROUND_Y = DEF_GROUND_Y,
   parameter int STEP_X   = 4,
   parameter int DASH_X   = 12,
   parameter int DASH_LEN = 6,
   parameter int DTAP_WIN = 8,
   parameter int V        = DEF_V,
   parameter int MAX_J    = DEF_MAX_J,
   parameter int KB_X     = 8,
   parameter int KB_LEN   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  frame_tick,
   input  logic                  right,
   input  logic                  left,
   input  logic                  jump,
   input  logic                  squat,
   input  logic                  defend,
   input  logic                  hit,
   input  logic                  hit_dir,
   input  logic signed [X_W-1:0] opp_x,
   output logic signed [X_W-1:0] x,
   output logic signed [Y_W-1:0] y,
   output logic                  isD,
   output logic                  isQ,
   output logic                  isJ,
   output logic                  is_dash,
   output logic                  is_hit,
   output logic                  facing,
   output logic                  landed,
   output logic                  blocked
);

   localparam int XE = X_W + 2;
   localparam int DW = cnt_bits(DASH_LEN);
   localparam int KW = cnt_bits(KB_LEN);
   localparam int WW = cnt_bits(DTAP_WIN);
   localparam logic signed [XE-1:0] XMIN_E = XE'(X_MIN);
   localparam logic signed [XE-1:0] XMAX_E = XE'(X_MAX);
   localparam logic signed [XE-1:0] STEP_E = XE'(STEP_X);
   localparam logic signed [XE-1:0] DASH_E = XE'(DASH_X);
   localparam logic signed [XE-1:0] KB_E   = XE'(KB_X);
   localparam logic signed [XE-1:0] KBH_E  = XE'(KB_X >> 1);

   h_state_t              h_state, h_nxt;
   logic [DW-1:0]         dash_cnt, dash_cnt_nxt;
   logic [KW-1:0]         kb_cnt, kb_cnt_nxt;
   logic [WW-1:0]         win_cnt, win_nxt;
   logic                  last_dir, last_dir_nxt, move_dir, move_dir_nxt;
   logic                  kb_half, kb_half_nxt, prev_r, prev_r_nxt, prev_l, prev_l_nxt;
   logic                  hit_lat, hit_lat_nxt, hit_dir_lat, hit_dir_lat_nxt, fac_init;
   logic signed [X_W-1:0] x_nxt;
   logic                  facing_nxt, isD_nxt, isQ_nxt, is_dash_nxt, is_hit_nxt, blocked_nxt;
   logic signed [XE-1:0]  x_ext, delta;
   logic                  gnd, walk_ok, isd_c, isq_c, rise_r, rise_l, rise_any, dtap;
   logic                  hit_now, hdir, jump_start;

   function automatic logic signed [X_W-1:0] sat_x(input logic signed [XE-1:0] v);
      if (v < XMIN_E) return X_W'(X_MIN);
      if (v > XMAX_E) return X_W'(X_MAX);
      return X_W'(v);
   endfunction

   function automatic logic signed [XE-1:0] signed_step(input logic dir,
                                                        input logic signed [XE-1:0] mag);
      return dir ? mag : -mag;
   endfunction

   // Pose decode for the current tick; defend outranks squat when both are held.
   always_comb begin
      gnd        = !isJ;
      walk_ok    = (h_state == H_WALK);
      isd_c      = defend & gnd & walk_ok;
      isq_c      = squat & !defend & gnd & walk_ok;
      rise_r     = right & !prev_r;
      rise_l     = left & !prev_l;
      rise_any   = rise_r | rise_l;
      dtap       = walk_ok & gnd & rise_any & (win_cnt != '0) & (last_dir == rise_r);
      hit_now    = hit_lat | hit;
      hdir       = hit ? hit_dir : hit_dir_lat;
      jump_start = jump & !isq_c & walk_ok;
      x_ext      = {{2{x[X_W-1]}}, x};
   end

   always_comb begin
      h_nxt           = h_state;
      dash_cnt_nxt    = dash_cnt;
      kb_cnt_nxt      = kb_cnt;
      win_nxt         = win_cnt;
      last_dir_nxt    = last_dir;
      move_dir_nxt    = move_dir;
      kb_half_nxt     = kb_half;
      prev_r_nxt      = prev_r;
      prev_l_nxt      = prev_l;
      hit_lat_nxt     = hit_lat;
      hit_dir_lat_nxt = hit_dir_lat;
      x_nxt           = x;
      facing_nxt      = facing;
      isD_nxt         = isD;
      isQ_nxt         = isQ;
      is_dash_nxt     = is_dash;
      is_hit_nxt      = is_hit;
      blocked_nxt     = 1'b0;
      delta           = '0;
      if (frame_tick) begin
         win_nxt     = (win_cnt != '0) ? win_cnt - WW'(1) : '0;
         prev_r_nxt  = right;
         prev_l_nxt  = left;
         hit_lat_nxt = 1'b0;
         is_dash_nxt = 1'b0;
         is_hit_nxt  = 1'b0;
         if (hit_now) begin
            // A defended hit pushes half as far for its whole duration and is reported as blocked.
            h_nxt        = (KB_LEN > 1) ? H_KNOCK : H_WALK;
            kb_cnt_nxt   = KW'(KB_LEN - 1);
            move_dir_nxt = hdir;
            kb_half_nxt  = isd_c;
            delta        = signed_step(hdir, isd_c ? KBH_E : KB_E);
            blocked_nxt  = isd_c;
            is_hit_nxt   = !isd_c;
         end else begin
            case (h_state)
               H_WALK: begin
                  if (dtap) begin
                     h_nxt        = (DASH_LEN > 1) ? H_DASH : H_WALK;
                     dash_cnt_nxt = DW'(DASH_LEN - 1);
                     move_dir_nxt = rise_r;
                     delta        = signed_step(rise_r, DASH_E);
                     is_dash_nxt  = 1'b1;
                     win_nxt      = '0;
                  end else begin
                     if (rise_any) begin
                        win_nxt      = WW'(DTAP_WIN);
                        last_dir_nxt = rise_r;
                     end
                     if (!isq_c && !isd_c && (right || left))
                        delta = signed_step(right, STEP_E);
                  end
               end
               H_DASH: begin
                  delta        = signed_step(move_dir, DASH_E);
                  is_dash_nxt  = 1'b1;
                  dash_cnt_nxt = dash_cnt - DW'(1);
                  if (dash_cnt <= DW'(1)) h_nxt = H_WALK;
               end
               H_KNOCK: begin
                  delta      = signed_step(move_dir, kb_half ? KBH_E : KB_E);
                  is_hit_nxt = !kb_half;
                  kb_cnt_nxt = kb_cnt - KW'(1);
                  if (kb_cnt <= KW'(1)) h_nxt = H_WALK;
               end
               default: h_nxt = H_WALK;
            endcase
         end
         x_nxt = sat_x(x_ext + delta);
         if (opp_x > x_nxt)      facing_nxt = 1'b1;
         else if (opp_x < x_nxt) facing_nxt = 1'b0;
         isD_nxt = isd_c;
         isQ_nxt = isq_c;
      end else begin
         if (hit) begin
            hit_lat_nxt     = 1'b1;
            hit_dir_lat_nxt = hit_dir;
         end
         // First clk out of reset: face the opponent before any tick has arrived.
         if (fac_init) facing_nxt = (opp_x > x);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         h_state     <= H_WALK;
         dash_cnt    <= '0;
         kb_cnt      <= '0;
         win_cnt     <= '0;
         last_dir    <= 1'b0;
         move_dir    <= 1'b0;
         kb_half     <= 1'b0;
         prev_r      <= 1'b0;
         prev_l      <= 1'b0;
         hit_lat     <= 1'b0;
         hit_dir_lat <= 1'b0;
         fac_init    <= 1'b1;
         x           <= X_W'(X_INIT);
         facing      <= 1'b0;
         isD         <= 1'b0;
         isQ         <= 1'b0;
         is_dash     <= 1'b0;
         is_hit      <= 1'b0;
         blocked     <= 1'b0;
      end else begin
         h_state     <= h_nxt;
         dash_cnt    <= dash_cnt_nxt;
         kb_cnt      <= kb_cnt_nxt;
         win_cnt     <= win_nxt;
         last_dir    <= last_dir_nxt;
         move_dir    <= move_dir_nxt;
         kb_half     <= kb_half_nxt;
         prev_r      <= prev_r_nxt;
         prev_l      <= prev_l_nxt;
         hit_lat     <= hit_lat_nxt;
         hit_dir_lat <= hit_dir_lat_nxt;
         fac_init    <= 1'b0;
         x           <= x_nxt;
         facing      <= facing_nxt;
         isD         <= isD_nxt;
         isQ         <= isQ_nxt;
         is_dash     <= is_dash_nxt;
         is_hit      <= is_hit_nxt;
         blocked     <= blocked_nxt;
      end
   end

   jump_arc #(
      .Y_W      (Y_W),
      .GROUND_Y (GROUND_Y),
      .V        (V),
      .MAX_J    (MAX_J)
   ) u_arc (
      .clk    (clk),
      .rst    (rst),
      .tick   (frame_tick),
      .start  (jump_start),
      .y      (y),
      .air    (isJ),
      .landed (landed)
   );

endmodule

// File: tb/tb_fighter_motion.sv
// Directed bench for fighter_motion: hand-computed x/y/flag values per scenario.
module tb_fighter_motion;

   logic clk = 1'b0;
   logic rst, frame_tick, right, left, jump, squat, defend, hit, hit_dir;
   logic signed [10:0] opp_x, x;
   logic signed [9:0]  y;
   logic isD, isQ, isJ, is_dash, is_hit, facing, landed, blocked;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fighter_motion dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .right(right), .left(left),
      .jump(jump), .squat(squat), .defend(defend), .hit(hit), .hit_dir(hit_dir),
      .opp_x(opp_x), .x(x), .y(y), .isD(isD), .isQ(isQ), .isJ(isJ), .is_dash(is_dash),
      .is_hit(is_hit), .facing(facing), .landed(landed), .blocked(blocked)
   );

   task automatic do_tick();
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) do_tick();
   endtask

   task automatic hit_pulse(input logic d);
      @(negedge clk); hit = 1'b1; hit_dir = d;
      @(negedge clk); hit = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_tick = 0; right = 0; left = 0; jump = 0; squat = 0;
      defend = 0; hit = 0; hit_dir = 0; opp_x = 11'sd500;
      repeat (2) @(negedge clk);
      n_cmp++; if (x !== 11'sd288) begin n_bad++; $display("FAIL rst_x got %0d want 288", x); end
      n_cmp++; if (y !== -10'sd176) begin n_bad++; $display("FAIL rst_y got %0d want -176", y); end
      n_cmp++; if ({isD, isQ, isJ, is_dash, is_hit, landed, blocked, facing} !== 8'b0) begin
         n_bad++; $display("FAIL rst_flags got %b want 00000000", {isD, isQ, isJ, is_dash, is_hit, landed, blocked, facing}); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (facing !== 1'b1) begin n_bad++; $display("FAIL rst_facing got %b want 1", facing); end
      n_cmp++; if (x !== 11'sd288) begin n_bad++; $display("FAIL rst_hold_x got %0d want 288", x); end
   endtask

   task automatic test_walk_clamp();
      right = 1; ticks(3);
      n_cmp++; if (x !== 11'sd288) begin n_bad++; $display("FAIL clamp_right got %0d want 288", x); end
      right = 0; left = 1; do_tick();
      n_cmp++; if (x !== 11'sd284) begin n_bad++; $display("FAIL walk_left1 got %0d want 284", x); end
      ticks(2);
      n_cmp++; if (x !== 11'sd276) begin n_bad++; $display("FAIL walk_left3 got %0d want 276", x); end
      squat = 1; do_tick();
      n_cmp++; if (x !== 11'sd276) begin n_bad++; $display("FAIL squat_nowalk got %0d want 276", x); end
      n_cmp++; if (isQ !== 1'b1) begin n_bad++; $display("FAIL squat_isQ got %b want 1", isQ); end
      squat = 0; left = 0; opp_x = 11'sd276; do_tick();
      n_cmp++; if (isQ !== 1'b0) begin n_bad++; $display("FAIL squat_clear got %b want 0", isQ); end
      n_cmp++; if (facing !== 1'b1) begin n_bad++; $display("FAIL facing_equal got %b want 1", facing); end
      opp_x = 11'sd250; do_tick();
      n_cmp++; if (facing !== 1'b0) begin n_bad++; $display("FAIL facing_left got %b want 0", facing); end
      opp_x = 11'sd500; do_tick();
      n_cmp++; if (facing !== 1'b1) begin n_bad++; $display("FAIL facing_right got %b want 1", facing); end
   endtask

   task automatic test_jump();
      jump = 1; do_tick(); jump = 0;
      n_cmp++; if (isJ !== 1'b1) begin n_bad++; $display("FAIL jump_isJ got %b want 1", isJ); end
      n_cmp++; if (y !== -10'sd176) begin n_bad++; $display("FAIL jump_y0 got %0d want -176", y); end
      do_tick();
      n_cmp++; if (y !== -10'sd168) begin n_bad++; $display("FAIL jump_y1 got %0d want -168", y); end
      ticks(15);
      n_cmp++; if (y !== -10'sd112) begin n_bad++; $display("FAIL jump_y16 got %0d want -112", y); end
      ticks(15);
      n_cmp++; if (y !== -10'sd168) begin n_bad++; $display("FAIL jump_y31 got %0d want -168", y); end
      n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL jump_early_land got %b want 0", landed); end
      do_tick();
      n_cmp++; if (y !== -10'sd176) begin n_bad++; $display("FAIL jump_y32 got %0d want -176", y); end
      n_cmp++; if (landed !== 1'b1) begin n_bad++; $display("FAIL jump_landed got %b want 1", landed); end
      n_cmp++; if (isJ !== 1'b0) begin n_bad++; $display("FAIL jump_isJ_end got %b want 0", isJ); end
      @(negedge clk);
      n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL landed_width got %b want 0", landed); end
   endtask

   task automatic test_dash();
      right = 1; ticks(3); right = 0;
      n_cmp++; if (x !== 11'sd288) begin n_bad++; $display("FAIL dash_pre_x got %0d want 288", x); end
      ticks(10);
      left = 1; defend = 1; do_tick();
      n_cmp++; if (isD !== 1'b1) begin n_bad++; $display("FAIL defend_isD got %b want 1", isD); end
      n_cmp++; if (x !== 11'sd288) begin n_bad++; $display("FAIL defend_nowalk got %0d want 288", x); end
      left = 0; defend = 0; do_tick();
      left = 1; do_tick();
      n_cmp++; if (x !== 11'sd276) begin n_bad++; $display("FAIL dash_x1 got %0d want 276", x); end
      n_cmp++; if (is_dash !== 1'b1) begin n_bad++; $display("FAIL dash_flag1 got %b want 1", is_dash); end
      for (int i = 0; i < 5; i++) begin
         do_tick();
         n_cmp++; if (is_dash !== 1'b1) begin n_bad++; $display("FAIL dash_flag%0d got %b want 1", i + 2, is_dash); end
      end
      n_cmp++; if (x !== 11'sd216) begin n_bad++; $display("FAIL dash_end_x got %0d want 216", x); end
      left = 0; do_tick();
      n_cmp++; if (is_dash !== 1'b0) begin n_bad++; $display("FAIL dash_done got %b want 0", is_dash); end
      n_cmp++; if (x !== 11'sd216) begin n_bad++; $display("FAIL dash_after_x got %0d want 216", x); end
   endtask

   task automatic test_no_tick();
      right = 1; defend = 1;
      repeat (100) @(negedge clk);
      n_cmp++; if (x !== 11'sd216) begin n_bad++; $display("FAIL hold_x got %0d want 216", x); end
      n_cmp++; if (isD !== 1'b0) begin n_bad++; $display("FAIL hold_isD got %b want 0", isD); end
      right = 0; defend = 0;
   endtask

   task automatic test_hit();
      left = 1; ticks(4); left = 0;
      n_cmp++; if (x !== 11'sd200) begin n_bad++; $display("FAIL hit_pre_x got %0d want 200", x); end
      ticks(10);
      hit_pulse(1'b1);
      n_cmp++; if (x !== 11'sd200) begin n_bad++; $display("FAIL hit_latched_x got %0d want 200", x); end
      do_tick();
      n_cmp++; if (x !== 11'sd208) begin n_bad++; $display("FAIL hit_x1 got %0d want 208", x); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (is_hit !== 1'b1) begin n_bad++; $display("FAIL hit_flag%0d got %b want 1", i + 1, is_hit); end
         do_tick();
      end
      n_cmp++; if (is_hit !== 1'b1) begin n_bad++; $display("FAIL hit_flag4 got %b want 1", is_hit); end
      n_cmp++; if (x !== 11'sd232) begin n_bad++; $display("FAIL hit_end_x got %0d want 232", x); end
      do_tick();
      n_cmp++; if (is_hit !== 1'b0 || x !== 11'sd232) begin
         n_bad++; $display("FAIL hit_done got is_hit=%b x=%0d want 0/232", is_hit, x); end
      left = 1; ticks(8); left = 0; do_tick();
      n_cmp++; if (x !== 11'sd200) begin n_bad++; $display("FAIL block_pre_x got %0d want 200", x); end
      defend = 1; hit_pulse(1'b1); do_tick();
      n_cmp++; if (x !== 11'sd204) begin n_bad++; $display("FAIL block_x1 got %0d want 204", x); end
      n_cmp++; if (blocked !== 1'b1) begin n_bad++; $display("FAIL blocked_pulse got %b want 1", blocked); end
      n_cmp++; if (is_hit !== 1'b0) begin n_bad++; $display("FAIL block_is_hit got %b want 0", is_hit); end
      @(negedge clk);
      n_cmp++; if (blocked !== 1'b0) begin n_bad++; $display("FAIL blocked_width got %b want 0", blocked); end
      defend = 0; ticks(3);
      n_cmp++; if (x !== 11'sd216) begin n_bad++; $display("FAIL block_end_x got %0d want 216", x); end
      n_cmp++; if (is_hit !== 1'b0) begin n_bad++; $display("FAIL block_is_hit_end got %b want 0", is_hit); end
   endtask

   task automatic test_hit_air();
      do_tick();
      jump = 1; do_tick(); jump = 0;
      ticks(10);
      n_cmp++; if (y !== -10'sd121) begin n_bad++; $display("FAIL air_y10 got %0d want -121", y); end
      hit_pulse(1'b0); do_tick();
      n_cmp++; if (x !== 11'sd208) begin n_bad++; $display("FAIL air_hit_x1 got %0d want 208", x); end
      n_cmp++; if (y !== -10'sd118) begin n_bad++; $display("FAIL air_y11 got %0d want -118", y); end
      n_cmp++; if (is_hit !== 1'b1 || isJ !== 1'b1) begin
         n_bad++; $display("FAIL air_hit_flags got is_hit=%b isJ=%b want 1/1", is_hit, isJ); end
      ticks(3);
      n_cmp++; if (x !== 11'sd184) begin n_bad++; $display("FAIL air_hit_end_x got %0d want 184", x); end
      n_cmp++; if (y !== -10'sd113) begin n_bad++; $display("FAIL air_y14 got %0d want -113", y); end
      ticks(17);
      n_cmp++; if (landed !== 1'b0 || y !== -10'sd168) begin
         n_bad++; $display("FAIL air_y31 got landed=%b y=%0d want 0/-168", landed, y); end
      do_tick();
      n_cmp++; if (landed !== 1'b1 || y !== -10'sd176 || isJ !== 1'b0) begin
         n_bad++; $display("FAIL air_land got landed=%b y=%0d isJ=%b want 1/-176/0", landed, y, isJ); end
   endtask

   task automatic test_rst_mid_dash();
      ticks(2);
      left = 1; do_tick(); left = 0; do_tick(); left = 1; do_tick(); left = 0;
      n_cmp++; if (x !== 11'sd168 || is_dash !== 1'b1) begin
         n_bad++; $display("FAIL min_dash1 got x=%0d is_dash=%b want 168/1", x, is_dash); end
      do_tick();
      n_cmp++; if (x !== 11'sd160) begin n_bad++; $display("FAIL clamp_min got %0d want 160", x); end
      do_tick();
      n_cmp++; if (x !== 11'sd160 || is_dash !== 1'b1) begin
         n_bad++; $display("FAIL clamp_min_hold got x=%0d is_dash=%b want 160/1", x, is_dash); end
      #2 rst = 1'b1;
      #1;
      n_cmp++; if (x !== 11'sd288 || y !== -10'sd176) begin
         n_bad++; $display("FAIL rst_dash_pos got x=%0d y=%0d want 288/-176", x, y); end
      n_cmp++; if ({isD, isQ, isJ, is_dash, is_hit, landed, blocked} !== 7'b0) begin
         n_bad++; $display("FAIL rst_dash_flags got %b want 0000000", {isD, isQ, isJ, is_dash, is_hit, landed, blocked}); end
      @(negedge clk); rst = 1'b0;
      do_tick();
      n_cmp++; if (x !== 11'sd288 || is_dash !== 1'b0) begin
         n_bad++; $display("FAIL rst_dash_after got x=%0d is_dash=%b want 288/0", x, is_dash); end
   endtask

   initial begin
      test_reset();
      test_walk_clamp();
      test_jump();
      test_dash();
      test_no_tick();
      test_hit();
      test_hit_air();
      test_rst_mid_dash();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
